// File: rtl/fp32_mul_pkg.sv
// ---------------------------------------------------------------------------
// fp32_mul_pkg : binary32 field layout and constants shared by fp32_mul
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp32_mul_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [11:0] EXP_BIAS = 12'd127;
  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

endpackage

`default_nettype wire

// File: rtl/fp32_mul_lzc.sv
// ---------------------------------------------------------------------------
// fp32_mul_lzc : 48-bit leading-zero counter (48 when the input is zero)
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp32_mul_lzc (
  input  logic [47:0] value,
  output logic [5:0]  count
);

  // Later (higher) set bits override earlier ones, leaving the MSB's distance.
  always_comb begin
    count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (value[i]) count = 6'(47 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_mul.sv
// ---------------------------------------------------------------------------
// fp32_mul : registered IEEE-754 binary32 multiplier, RNE, 1-cycle latency.
//            Define FP32_MUL_DENORM_EN for subnormal support (else flush).
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp32_mul
  import fp32_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        out_valid
);

  fp32_t              a, b;
  logic               sign;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [7:0]         ea_eff, eb_eff;
  logic [23:0]        ma, mb;
  logic [47:0]        prod, norm, sel;
  logic [5:0]         lz;
  logic signed [11:0] exp_n;
  logic [7:0]         field_base;
  logic               lost, rnd;
  logic [30:0]        rounded;
  logic [31:0]        result;
  logic [31:0]        out_d, out_q;
  logic               out_valid_d, out_valid_q;
`ifdef FP32_MUL_DENORM_EN
  logic [11:0]        sh;
`endif

  assign a = in1;
  assign b = in2;

  always_comb begin
    sign   = a.sign ^ b.sign;
    nan_a  = (a.exp == EXP_MAX) && (a.frac != 23'd0);
    nan_b  = (b.exp == EXP_MAX) && (b.frac != 23'd0);
    inf_a  = (a.exp == EXP_MAX) && (a.frac == 23'd0);
    inf_b  = (b.exp == EXP_MAX) && (b.frac == 23'd0);
`ifdef FP32_MUL_DENORM_EN
    zero_a = (a.exp == 8'd0) && (a.frac == 23'd0);
    zero_b = (b.exp == 8'd0) && (b.frac == 23'd0);
`else
    zero_a = (a.exp == 8'd0);
    zero_b = (b.exp == 8'd0);
`endif
    // Subnormals carry a hidden 0 and behave as exponent 1.
    ea_eff = (a.exp == 8'd0) ? 8'd1 : a.exp;
    eb_eff = (b.exp == 8'd0) ? 8'd1 : b.exp;
    ma     = {a.exp != 8'd0, a.frac};
    mb     = {b.exp != 8'd0, b.frac};
  end

  assign prod = ma * mb;

  fp32_mul_lzc u_lzc (
    .value (prod),
    .count (lz)
  );

  always_comb begin
    norm       = prod << lz;
    exp_n      = $signed({4'd0, ea_eff} + {4'd0, eb_eff} - EXP_BIAS + 12'd1 - {6'd0, lz});
    sel        = norm;
    lost       = 1'b0;
    // Hidden bit sel[47] is added on top of exp-1, so a carry bumps the exponent.
    field_base = exp_n[7:0] - 8'd1;
`ifdef FP32_MUL_DENORM_EN
    sh = 12'd0;
    if (exp_n <= 12'sd0) begin
      sh         = 12'd1 - $unsigned(exp_n);
      sel        = norm >> sh;
      lost       = |(norm & ~({48{1'b1}} << sh));
      field_base = 8'd0;
    end
`endif
    rnd     = sel[23] & (sel[22] | (|sel[21:0]) | lost | sel[24]);
    rounded = {field_base, 23'd0} + {7'd0, sel[47:24]} + {30'd0, rnd};

    if (nan_a || nan_b) begin
      result = QNAN;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      result = QNAN;
    end else if (inf_a || inf_b) begin
      result = sign ? NEG_INF : POS_INF;
    end else if (zero_a || zero_b) begin
      result = {sign, 31'd0};
    end else if (exp_n >= 12'sd255) begin
      result = sign ? NEG_INF : POS_INF;
`ifndef FP32_MUL_DENORM_EN
    end else if (exp_n <= 12'sd0) begin
      result = {sign, 31'd0};
`endif
    end else begin
      result = {sign, rounded};
    end
  end

  always_comb begin
    out_valid_d = in_valid;
    out_d       = in_valid ? result : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fp32_mul.sv
// ---------------------------------------------------------------------------
// tb_fp32_mul : directed scoreboard bench for fp32_mul
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp32_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in1, in2;
  logic [31:0] out;
  logic        out_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  fp32_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
  endtask

  // Scoreboard: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check(tag_q.pop_front(), out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in1      = 32'h4000_0000;
    in2      = 32'h4000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", out, 32'h0000_0000);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    step(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, "2x1");
    step(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, "2x2");
    step(32'h40A8_0000, 32'h4000_0000, 32'h4128_0000, "5.25x2");
    step(32'hBF80_0000, 32'h4000_0000, 32'hC000_0000, "neg1x2");
    step(32'h4020_0000, 32'h4060_0000, 32'h410C_0000, "2.5x3.5");
    step(32'h44FC_7333, 32'hFF80_0001, 32'h7FC0_0000, "nan_operand");
    step(32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, "snan_operand");
    step(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero");
    step(32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, "zero_x_inf");
    step(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zero_x_zero");
    step(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "negzero_x_1");
    step(32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, "ninf_x_inf");
    step(32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000, "ninf_x_ninf");
    step(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, "inf_x_neg2");
    step(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "overflow");
    step(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "rne_near");
    step(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, "tie_odd_up");
    step(32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, "tie_even_keep");
    step(32'h3F84_2108, 32'h3FF8_0000, 32'h4000_0000, "round_carry");
`ifdef FP32_MUL_DENORM_EN
    step(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, "tiny_result");
`else
    step(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "tiny_result");
`endif

    // Hold: a bubble drops out_valid while out keeps the last product.
    step(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, "3x3");
    idle();
    @(posedge clk);
    @(negedge clk);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_out", out, 32'h4110_0000);

    // Reset in mid-stream discards the operands presented with it.
    step(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, "2x3");
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in1      = 32'h4080_0000;
    in2      = 32'h4080_0000;
    @(posedge clk);
    @(negedge clk);
    check("midreset_out", out, 32'h0000_0000);
    check("midreset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    step(32'hC000_0000, 32'hC080_0000, 32'h4100_0000, "post_reset");
    idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp32_mul.md
FP32_MUL -- requirements
Module: fp32_mul

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 binary32.
REQ-002 SHALL have port: clk  input  1  single rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operands valid this cycle.
REQ-005 SHALL have port: in1  input  32  operand A (binary32: sign[31], exp[30:23], frac[22:0]).
REQ-006 SHALL have port: in2  input  32  operand B (binary32).
REQ-007 SHALL have port: out  output  32  registered product A*B (binary32).
REQ-008 SHALL have port: out_valid  output  1  out holds the result of the operands sampled on the previous cycle.

Function
REQ-009 SHALL compute the product combinationally and register it, giving 1-cycle latency: operands sampled at edge N appear on out/out_valid after edge N+1.
REQ-010 SHALL accept a new operand pair every cycle; when in_valid=0, out_valid SHALL go to 0 and out SHALL hold its last value.
REQ-011 Sign of every non-NaN result SHALL be sign(in1) XOR sign(in2).
REQ-012 Finite case: 24x24 significand product (implicit 1 for normals), exponent = eA+eB-127, normalised to 1.f.
REQ-013 Rounding SHALL be round-to-nearest, ties-to-even, using guard, round and sticky bits from the 48-bit product.
REQ-014 A mantissa carry-out after rounding SHALL increment the exponent.
REQ-015 A biased result exponent >= 255 after rounding SHALL give signed infinity (exp=0xFF, frac=0).
REQ-016 Any NaN operand (exp=0xFF, frac!=0), including a signalling NaN, SHALL give the canonical quiet NaN 0x7FC00000.
REQ-017 Infinity times zero, in either operand order, SHALL give 0x7FC00000.
REQ-018 Infinity times a nonzero finite value or infinity SHALL give signed infinity.
REQ-019 Zero times a finite value SHALL give signed zero; for example -0 * +x = 0x80000000.
REQ-020 Special-case priority SHALL be NaN, then Inf*0, then Inf, then zero, then the finite path.
REQ-021 Results below the minimum normal SHALL follow REQ-028/REQ-029.

Reset
REQ-022 While rst=1 at a clock edge, out SHALL become 0x00000000 and out_valid SHALL become 0.
REQ-023 Operands present during a reset cycle SHALL be discarded; the first valid result appears one cycle after the first post-reset in_valid sample.
REQ-024 No state SHALL exist other than the out and out_valid registers.

Configuration
REQ-025 Subnormal support SHALL be compiled in by the macro FP32_MUL_DENORM_EN.
REQ-026 With FP32_MUL_DENORM_EN defined, subnormal operands SHALL use implicit bit 0 and exponent 1, with normalisation by leading-zero count.
REQ-027 With FP32_MUL_DENORM_EN defined, tiny results SHALL be right-shifted into subnormal form and rounded per REQ-013; rounding up to the minimum normal SHALL produce exp=1.
REQ-028 Without FP32_MUL_DENORM_EN, any operand with exp=0 SHALL be treated as signed zero.
REQ-029 Without FP32_MUL_DENORM_EN, any result with biased exponent <= 0 SHALL be flushed to signed zero.

Structure
REQ-030 Package fp32_mul_pkg SHALL hold:
- binary32 field typedef (sign/exp/frac);
- constants EXP_BIAS=127, EXP_MAX=255 and QNAN=32'h7FC00000;
- POS_INF/NEG_INF constants.
REQ-031 One sub-module, fp32_mul_lzc (48-bit leading-zero counter), SHALL be used for normalisation when FP32_MUL_DENORM_EN is set.

Verification
REQ-032 Normal products, each with in_valid=1 -> out one cycle later:
- 0x40000000*0x3F800000 -> 0x40000000;
- 0x40000000*0x40000000 -> 0x40800000;
- 0x40A80000*0x40000000 -> 0x41280000.
REQ-033 Sign and rounding-free products:
- 0xBF800000*0x40000000 -> 0xC0000000;
- 0x40200000*0x40600000 (2.5*3.5) -> 0x410C0000.
REQ-034 NaN and invalid cases:
- 0x44FC7333*0xFF800001 -> 0x7FC00000;
- 0x7F800000*0x00000000 -> 0x7FC00000.
REQ-035 Zero and infinity cases:
- 0x00000000*0x00000000 -> 0x00000000;
- 0xFF800000*0x7F800000 -> 0xFF800000;
- 0xFF800000*0xFF800000 -> 0x7F800000.
REQ-036 Overflow and tie rounding:
- 0x7F000000*0x40000000 -> 0x7F800000;
- 0x3F800001*0x3F800001 -> 0x3F800002 (round-to-nearest);
- a constructed exact tie SHALL round to the even mantissa.
REQ-037 Reset and subnormal cases:
- rst=1 mid-stream -> out=0 and out_valid=0 next edge;
- with FP32_MUL_DENORM_EN, 0x00800000*0x3F000000 -> 0x00400000;
- without it, the same operands -> 0x00000000.
